watch_set_ctrl: RTL and testbench

Single-clock time-keeping and time-setting controller for the watch counter chain.
- In RUN mode it prescales the 1 Hz tick into a seconds count and issues one minute-tick enable per 60 s to the minute-units counter.
- In SET modes it cycles through the hour, minute-tens and minute-units digits on MODE presses.
- In SET modes it issues per-digit increment pulses on INC presses, with auto-repeat, and suppresses inter-digit carries.
- It drives blink control for the display and falls back to RUN after an idle timeout.

---
 rtl/watch_set_ctrl.sv | 170 +++++++++++++++++
 tb/tb_watch_set_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/watch_set_ctrl.sv
// Watch time-keeping / time-setting controller: seconds prescaler, digit-select FSM,
// INC pulse generation with auto-repeat, display blink and idle timeout back to RUN.
module watch_set_ctrl #(
  parameter int SEC_PER_MIN = 60,
  parameter int HOLD_CYC    = 16384,
  parameter int REPEAT_CYC  = 4096,
  parameter int TIMEOUT_S   = 30
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_1hz_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  output logic       min_tick_o,
  output logic       inc_o,
  output logic [1:0] inc_sel_o,
  output logic       carry_en_o,
  output logic [1:0] mode_o,
  output logic       blink_o,
  output logic [5:0] sec_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_H   = 2'd1,
    SET_M10 = 2'd2,
    SET_M1  = 2'd3
  } state_t;

  localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT_S + 1);

  // The edge cycle already emits the first pulse, so the hold phase ends one count early.
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYC - 2);
  localparam logic [CNT_W-1:0]  REP_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_S - 1);
  localparam logic [5:0]        SEC_LAST  = 6'(SEC_PER_MIN - 1);

  state_t            state_reg;
  logic              inc_active_reg;
  logic              repeating_reg;
  logic [CNT_W-1:0]  hold_cnt_reg;
  logic [IDLE_W-1:0] idle_cnt_reg;

  logic [1:0] btn;
  logic [1:0] btn_edge;
  logic       mode_edge;
  logic       inc_edge;
  logic       in_set;
  logic       repeat_fire;
  logic       timeout;

  assign btn = {btn_inc_i, btn_mode_i};

  // Previous level also tracks during reset, so a button held across reset release is no edge.
  for (genvar gi = 0; gi < 2; gi++) begin : g_edge
    logic prev_reg;
    always_ff @(posedge clk_i) begin
      prev_reg <= btn[gi];
    end
    assign btn_edge[gi] = btn[gi] & ~prev_reg;
  end

  assign mode_edge = btn_edge[0];
  assign inc_edge  = btn_edge[1];
  assign in_set    = (state_reg != RUN);

  assign repeat_fire = inc_active_reg & btn_inc_i & ~mode_edge &
                       (repeating_reg ? (hold_cnt_reg == REP_LAST)
                                      : (hold_cnt_reg == HOLD_LAST));

  assign timeout = in_set & tick_1hz_i & (idle_cnt_reg == IDLE_LAST) &
                   ~mode_edge & ~inc_edge & ~repeat_fire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= RUN;
      sec_o          <= 6'd0;
      min_tick_o     <= 1'b0;
      inc_o          <= 1'b0;
      blink_o        <= 1'b1;
      inc_active_reg <= 1'b0;
      repeating_reg  <= 1'b0;
      hold_cnt_reg   <= '0;
      idle_cnt_reg   <= '0;
    end else begin
      min_tick_o <= 1'b0;
      inc_o      <= 1'b0;
      case (state_reg)
        RUN: begin
          blink_o        <= 1'b1;
          inc_active_reg <= 1'b0;
          repeating_reg  <= 1'b0;
          hold_cnt_reg   <= '0;
          if (mode_edge) begin
            state_reg    <= SET_H;
            idle_cnt_reg <= '0;
          end else if (tick_1hz_i) begin
            if (sec_o == SEC_LAST) begin
              sec_o      <= 6'd0;
              min_tick_o <= 1'b1;
            end else begin
              sec_o <= sec_o + 6'd1;
            end
          end
        end
        default: begin
          if (mode_edge) begin
            state_reg      <= state_t'(state_reg + 2'd1);
            blink_o        <= 1'b1;
            idle_cnt_reg   <= '0;
            inc_active_reg <= 1'b0;
            repeating_reg  <= 1'b0;
            hold_cnt_reg   <= '0;
            if (state_reg == SET_M1) sec_o <= 6'd0;
          end else if (timeout) begin
            state_reg      <= RUN;
            blink_o        <= 1'b1;
            sec_o          <= 6'd0;
            idle_cnt_reg   <= '0;
            inc_active_reg <= 1'b0;
            repeating_reg  <= 1'b0;
            hold_cnt_reg   <= '0;
          end else begin
            if (tick_1hz_i) blink_o <= ~blink_o;
            if (inc_edge) begin
              inc_o          <= 1'b1;
              inc_active_reg <= 1'b1;
              repeating_reg  <= 1'b0;
              hold_cnt_reg   <= '0;
            end else if (inc_active_reg && btn_inc_i) begin
              if (repeat_fire) begin
                inc_o         <= 1'b1;
                repeating_reg <= 1'b1;
                hold_cnt_reg  <= '0;
              end else begin
                hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
              end
            end else begin
              inc_active_reg <= 1'b0;
              repeating_reg  <= 1'b0;
              hold_cnt_reg   <= '0;
            end
            // Any user activity restarts the idle window, even if a tick lands in the same cycle.
            if (inc_edge || repeat_fire) begin
              idle_cnt_reg <= '0;
            end else if (tick_1hz_i) begin
              idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    inc_sel_o = 2'd3;
    case (state_reg)
      SET_H:   inc_sel_o = 2'd2;
      SET_M10: inc_sel_o = 2'd1;
      SET_M1:  inc_sel_o = 2'd0;
      default: inc_sel_o = 2'd3;
    endcase
  end

  assign carry_en_o = (state_reg == RUN);
  assign mode_o     = state_reg;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Directed bench for watch_set_ctrl: a single-cycle vector table plus hand-written
// sequences for the seconds wrap, auto-repeat, idle timeout and reset mid-repeat.
module tb_watch_set_ctrl;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       btn_mode;
  logic       btn_inc;
  logic       min_tick;
  logic       inc;
  logic [1:0] inc_sel;
  logic       carry_en;
  logic [1:0] mode;
  logic       blink;
  logic [5:0] sec;

  int n_cmp = 0;
  int n_bad = 0;

  watch_set_ctrl #(
    .SEC_PER_MIN(60),
    .HOLD_CYC   (8),
    .REPEAT_CYC (3),
    .TIMEOUT_S  (4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .tick_1hz_i(tick),
    .btn_mode_i(btn_mode),
    .btn_inc_i (btn_inc),
    .min_tick_o(min_tick),
    .inc_o     (inc),
    .inc_sel_o (inc_sel),
    .carry_en_o(carry_en),
    .mode_o    (mode),
    .blink_o   (blink),
    .sec_o     (sec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r, t, m, i;
    logic [1:0] e_mode, e_sel;
    logic       e_carry, e_inc, e_min, e_blink;
    logic [5:0] e_sec;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, return at the next fall.
  task automatic step(input logic r, input logic t, input logic m, input logic i);
    rst = r; tick = t; btn_mode = m; btn_inc = i;
    @(negedge clk);
    chk("inc_min_excl", int'(inc & min_tick), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mode"},  mode,     0);
    chk({tag, "_sel"},   inc_sel,  3);
    chk({tag, "_carry"}, carry_en, 1);
    chk({tag, "_inc"},   inc,      0);
    chk({tag, "_min"},   min_tick, 0);
    chk({tag, "_blink"}, blink,    1);
    chk({tag, "_sec"},   sec,      0);
  endtask

  initial begin
    int mins;
    int pulses;
    rst = 1'b1; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    @(negedge clk);

    //           r  t  m  i   mode sel carry inc min blink sec
    tbl[0]  = '{1, 0, 0, 0,  0, 3, 1, 0, 0, 1, 0};
    tbl[1]  = '{0, 1, 0, 0,  0, 3, 1, 0, 0, 1, 1};
    tbl[2]  = '{0, 1, 0, 0,  0, 3, 1, 0, 0, 1, 2};
    tbl[3]  = '{0, 1, 0, 1,  0, 3, 1, 0, 0, 1, 3};
    tbl[4]  = '{0, 0, 1, 0,  1, 2, 0, 0, 0, 1, 3};
    tbl[5]  = '{0, 1, 0, 0,  1, 2, 0, 0, 0, 0, 3};
    tbl[6]  = '{0, 0, 0, 1,  1, 2, 0, 1, 0, 0, 3};
    tbl[7]  = '{0, 0, 0, 0,  1, 2, 0, 0, 0, 0, 3};
    tbl[8]  = '{0, 0, 1, 1,  2, 1, 0, 0, 0, 1, 3};
    tbl[9]  = '{0, 1, 0, 0,  2, 1, 0, 0, 0, 0, 3};
    tbl[10] = '{0, 0, 1, 1,  3, 0, 0, 0, 0, 1, 3};
    tbl[11] = '{0, 0, 0, 1,  3, 0, 0, 0, 0, 1, 3};
    tbl[12] = '{0, 1, 0, 0,  3, 0, 0, 0, 0, 0, 3};
    tbl[13] = '{0, 1, 1, 0,  0, 3, 1, 0, 0, 1, 0};
    tbl[14] = '{0, 1, 0, 0,  0, 3, 1, 0, 0, 1, 1};

    for (int k = 0; k < 15; k++) begin
      step(tbl[k].r, tbl[k].t, tbl[k].m, tbl[k].i);
      chk($sformatf("v%0d_mode", k),  mode,     tbl[k].e_mode);
      chk($sformatf("v%0d_sel", k),   inc_sel,  tbl[k].e_sel);
      chk($sformatf("v%0d_carry", k), carry_en, tbl[k].e_carry);
      chk($sformatf("v%0d_inc", k),   inc,      tbl[k].e_inc);
      chk($sformatf("v%0d_min", k),   min_tick, tbl[k].e_min);
      chk($sformatf("v%0d_blink", k), blink,    tbl[k].e_blink);
      chk($sformatf("v%0d_sec", k),   sec,      tbl[k].e_sec);
      $display("vec %0d: mode=%0d sel=%0d carry=%0d inc=%0d min=%0d blink=%0d sec=%0d",
               k, mode, inc_sel, carry_en, inc, min_tick, blink, sec);
    end

    // Two full minutes in RUN: minute tick right after the 60th and 120th tick sample.
    step(1, 0, 0, 0);
    chk_reset_vals("rst_a");
    mins = 0;
    for (int i = 1; i <= 120; i++) begin
      step(0, 1, 0, 0);
      chk($sformatf("run_min_t%0d", i), min_tick, (i % 60 == 0) ? 1 : 0);
      chk($sformatf("run_sec_t%0d", i), sec, i % 60);
      if (min_tick) mins++;
      step(0, 0, 0, 0);
      chk($sformatf("run_min_gap%0d", i), min_tick, 0);
    end
    chk("run_min_total", mins, 2);
    $display("run: 120 ticks, %0d minute ticks, sec=%0d", mins, sec);

    // Auto-repeat in SET_M10 with INC held 20 cycles.
    step(1, 0, 0, 0);
    step(0, 0, 1, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 0); step(0, 0, 0, 0);
    chk("rep_mode", mode, 2);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      int c;
      c = k + 1;
      step(0, 0, 0, 1);
      chk($sformatf("rep_c%0d", c), inc,
          (c == 1 || c == 8 || c == 11 || c == 14 || c == 17 || c == 20) ? 1 : 0);
      chk($sformatf("rep_sel_c%0d", c), inc_sel, 1);
      if (inc) pulses++;
    end
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 0);
      chk($sformatf("rep_rel%0d", k), inc, 0);
    end
    chk("rep_total", pulses, 6);
    $display("repeat: %0d pulses over 20 held cycles", pulses);

    // Idle timeout after 4 ticks; SET exit reloads seconds to zero.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    chk("to_sec_pre", sec, 5);
    step(0, 0, 1, 0); step(0, 0, 0, 0);
    chk("to_enter", mode, 1);
    for (int n = 1; n <= 4; n++) begin
      step(0, 1, 0, 0);
      chk($sformatf("to_mode_t%0d", n), mode, (n < 4) ? 1 : 0);
    end
    chk("to_sec", sec, 0);
    chk("to_blink", blink, 1);
    chk("to_carry", carry_en, 1);
    $display("timeout: mode=%0d sec=%0d", mode, sec);

    // An INC edge after tick 2 restarts the idle window: exit on tick 6.
    step(0, 0, 1, 0); step(0, 0, 0, 0);
    for (int n = 1; n <= 2; n++) begin
      step(0, 1, 0, 0);
      chk($sformatf("to2_mode_t%0d", n), mode, 1);
    end
    step(0, 0, 0, 1);
    chk("to2_inc", inc, 1);
    step(0, 0, 0, 0);
    for (int n = 3; n <= 6; n++) begin
      step(0, 1, 0, 0);
      chk($sformatf("to2_mode_t%0d", n), mode, (n < 6) ? 1 : 0);
    end
    $display("timeout2: mode=%0d", mode);

    // Reset lands mid-repeat: everything returns to reset values, no further pulses.
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0); step(0, 0, 0, 0);
    end
    chk("rr_mode", mode, 3);
    for (int k = 0; k < 12; k++) begin
      int c;
      c = k + 1;
      step(0, 0, 0, 1);
      chk($sformatf("rr_c%0d", c), inc, (c == 1 || c == 8 || c == 11) ? 1 : 0);
    end
    step(1, 0, 0, 1);
    chk_reset_vals("rr_rst");
    for (int k = 0; k < 15; k++) begin
      step(0, 0, 0, 1);
      chk($sformatf("rr_after%0d", k), inc, 0);
    end
    chk("rr_end_mode", mode, 0);
    chk("rr_end_sel", inc_sel, 3);
    $display("reset-mid-repeat: mode=%0d inc=%0d", mode, inc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
